transposer_arbiter: RTL and testbench

Round-robin scheduler that shares one `transposer` instance between `NREQ` matrix requesters. It grants one requester at a time, drives the transposer's `input_ready`/`output_taken` handshake, and returns the transposed matrix to the granted requester through a valid/ready response. It sits between the requester-side datapath blocks and the single transposer, and counts completed jobs.

---
 rtl/transposer_arbiter.sv | 125 ++++++++++++
 tb/tb_transposer_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/transposer_arbiter.sv
// Round-robin owner of a single shared transposer: grants one requester per job,
// drives the transposer handshake and returns the transposed matrix over valid/ready.
module transposer_arbiter #(
    parameter int IL   = 8,
    parameter int FL   = 12,
    parameter int row  = 4,
    parameter int col  = 4,
    parameter int NREQ = 4,
    localparam int W   = IL + FL,
    localparam int OW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NREQ-1:0]                         req,
    input  logic [NREQ-1:0][row-1:0][col-1:0][W-1:0] req_data,
    output logic [NREQ-1:0]                         grant,
    output logic [NREQ-1:0]                         rsp_valid,
    input  logic [NREQ-1:0]                         rsp_ready,
    output logic [col-1:0][row-1:0][W-1:0]          rsp_data,
    input  logic [1:0]                              t_state,
    output logic                                    t_input_ready,
    output logic                                    t_output_taken,
    output logic [row-1:0][col-1:0][W-1:0]          t_in,
    input  logic [col-1:0][row-1:0][W-1:0]          t_out,
    output logic [15:0]                             job_count,
    output logic                                    err_proto
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [15:0]     job_count_q, job_count_d;
    logic            err_q, err_d;

    logic            win_found;
    logic [OW-1:0]   win_idx;
    logic [OW-1:0]   owner_nxt;
    logic            rsp_hot;
    int              idx;

    // First requester at or above rr_ptr, searching upward with wrap-around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = OW'(idx);
            end
        end
    end

    assign owner_nxt = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign rsp_hot   = (state_q == RUN) && (t_state == 2'b10);

    assign grant          = grant_q;
    assign job_count      = job_count_q;
    assign err_proto      = err_q;
    assign t_input_ready  = (state_q == LOAD);
    assign t_in           = (state_q == LOAD) ? req_data[owner_q] : '0;
    assign rsp_valid      = rsp_hot ? (NREQ'(1) << owner_q) : '0;
    assign rsp_data       = rsp_hot ? t_out : '0;
    assign t_output_taken = rsp_hot & rsp_ready[owner_q];

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        job_count_d = job_count_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (win_found && t_state == 2'b00) begin
                    owner_d = win_idx;
                    grant_d = NREQ'(1) << win_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (t_state != 2'b00) err_d = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (t_output_taken) begin
                    job_count_d = job_count_q + 16'd1;
                    rr_ptr_d    = owner_nxt;
                    grant_d     = '0;
                    state_d     = IDLE;
                end else if (t_state == 2'b00) begin
                    // Transposer dropped the job: abandon it without a response.
                    err_d    = 1'b1;
                    rr_ptr_d = owner_nxt;
                    grant_d  = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            job_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            job_count_q <= job_count_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_transposer_arbiter.sv
// Bench for transposer_arbiter: behavioural transposer, vector table of jobs,
// scoreboard of expected responses, and hand-written corner sequences.
module tb_transposer_arbiter;
    localparam int IL = 8, FL = 12, W = IL + FL, R = 4, C = 4, N = 4;

    typedef logic [R-1:0][C-1:0][W-1:0] imat_t;
    typedef logic [C-1:0][R-1:0][W-1:0] omat_t;
    typedef struct { int owner; omat_t data; } sb_t;
    typedef struct { logic [N-1:0] mask; int exp_g; bit chk_gap; } vec_t;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [N-1:0]        req = '0;
    logic [N-1:0]        rsp_ready = '0;
    imat_t [N-1:0]       req_data;
    logic [N-1:0]        grant, rsp_valid;
    omat_t               rsp_data, t_out, tbuf;
    logic [1:0]          t_state, ts;
    logic                t_input_ready, t_output_taken, err_proto;
    imat_t               t_in;
    logic [15:0]         job_count;
    logic                drop = 1'b0;

    int total = 0, bad = 0, cyc = 0, last_grant = 0;
    sb_t sbq[$];
    vec_t vt[9];

    transposer_arbiter #(.IL(IL), .FL(FL), .row(R), .col(C), .NREQ(N)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .t_state(t_state), .t_input_ready(t_input_ready),
        .t_output_taken(t_output_taken), .t_in(t_in), .t_out(t_out),
        .job_count(job_count), .err_proto(err_proto)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural transposer; 'drop' makes it abandon the job instead of finishing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts   <= 2'b00;
            tbuf <= '0;
        end else begin
            case (ts)
                2'b00: if (t_input_ready) begin
                    ts <= 2'b01;
                    for (int i = 0; i < R; i++)
                        for (int j = 0; j < C; j++)
                            tbuf[j][i] <= t_in[i][j];
                end
                2'b01: ts <= drop ? 2'b00 : 2'b10;
                2'b10: if (t_output_taken) ts <= 2'b00;
                default: ts <= 2'b00;
            endcase
        end
    end
    assign t_state = ts;
    assign t_out   = (ts == 2'b10) ? tbuf : '0;

    function automatic omat_t exp_mat(input int r);
        omat_t m;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                m[j][i] = W'(16 * i + j + 256 * r);
        return m;
    endfunction

    task automatic chk(input string nm, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic chk_mat(input string nm, input omat_t act, input omat_t expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    task automatic wait_grant();
        int n = 0;
        do begin @(negedge clk); n++; end while (grant == '0 && n < 20);
    endtask

    task automatic wait_rsp();
        int n = 0;
        do begin @(negedge clk); n++; end while (rsp_valid == '0 && n < 20);
    endtask

    // One job with rsp_ready high; returns at the negedge of the following IDLE cycle.
    task automatic do_job(input logic [N-1:0] mask, input int eg, input bit chk_gap);
        int rcyc, gcyc;
        sb_t s;
        req  = mask;
        rcyc = cyc;
        wait_grant();
        gcyc = cyc;
        chk("grant", longint'(grant), longint'(1) << eg);
        chk("req_to_grant", gcyc - rcyc, 1);
        chk("load_input_ready", longint'(t_input_ready), 1);
        if (chk_gap) chk("grant_gap", gcyc - last_grant, 4);
        last_grant = gcyc;
        s.owner = eg;
        s.data  = exp_mat(eg);
        sbq.push_back(s);
        wait_rsp();
        chk("grant_to_rsp", cyc - gcyc, 2);
        if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard: response with empty queue");
        end else begin
            s = sbq.pop_front();
            chk("rsp_valid", longint'(rsp_valid), longint'(1) << s.owner);
            chk_mat("rsp_data", rsp_data, s.data);
        end
        chk("output_taken", longint'(t_output_taken), 1);
        @(negedge clk);
        chk("grant_cleared", longint'(grant), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < N; r++)
            for (int i = 0; i < R; i++)
                for (int j = 0; j < C; j++)
                    req_data[r][i][j] = W'(16 * i + j + 256 * r);

        vt[0] = '{4'b0001, 0, 1'b0};  // single job
        vt[1] = '{4'b0100, 2, 1'b1};  // rr_ptr -> 3
        vt[2] = '{4'b0101, 0, 1'b1};  // wrap past 3, skip to 0
        vt[3] = '{4'b0101, 2, 1'b1};
        vt[4] = '{4'b1111, 3, 1'b1};
        vt[5] = '{4'b1111, 0, 1'b1};
        vt[6] = '{4'b1111, 1, 1'b1};
        vt[7] = '{4'b1111, 2, 1'b1};
        vt[8] = '{4'b1111, 3, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_grant", longint'(grant), 0);
        chk("rst_job_count", longint'(job_count), 0);
        chk("rst_err", longint'(err_proto), 0);
        chk("rst_input_ready", longint'(t_input_ready), 0);
        reset     = 1'b1;
        rsp_ready = 4'b1111;
        @(negedge clk);

        foreach (vt[k]) do_job(vt[k].mask, vt[k].exp_g, vt[k].chk_gap);
        chk("job_count_table", longint'(job_count), 9);

        // Backpressure: owner 0 withholds rsp_ready for 10 cycles
        rsp_ready = '0;
        req = 4'b1111;
        wait_grant();
        chk("bp_grant", longint'(grant), 1);
        wait_rsp();
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            rsp_ready = (k == 4) ? 4'b1110 : 4'b0000;
            #1;
            chk("bp_rsp_valid", longint'(rsp_valid), 1);
            chk_mat("bp_rsp_data", rsp_data, exp_mat(0));
            chk("bp_taken", longint'(t_output_taken), 0);
            chk("bp_grant_hold", longint'(grant), 1);
        end
        @(negedge clk);
        rsp_ready = 4'b1111;
        #1;
        chk("bp_taken_release", longint'(t_output_taken), 1);
        @(negedge clk);
        chk("bp_grant_cleared", longint'(grant), 0);
        chk("bp_job_count", longint'(job_count), 10);

        // Protocol error: transposer drops the job during RUN
        drop = 1'b1;
        req  = 4'b0010;
        wait_grant();
        chk("err_grant", longint'(grant), 2);
        @(negedge clk);
        chk("err_no_rsp_c2", longint'(rsp_valid), 0);
        @(negedge clk);
        chk("err_no_rsp_c3", longint'(rsp_valid), 0);
        chk("err_no_taken", longint'(t_output_taken), 0);
        @(negedge clk);
        drop = 1'b0;
        chk("err_set", longint'(err_proto), 1);
        chk("err_grant_cleared", longint'(grant), 0);
        chk("err_job_count", longint'(job_count), 10);
        do_job(4'b0010, 1, 1'b0);
        chk("err_sticky", longint'(err_proto), 1);
        chk("err_after_job_count", longint'(job_count), 11);

        // Asynchronous reset mid-job
        req = 4'b0100;
        wait_grant();
        chk("rst_mid_grant", longint'(grant), 4);
        wait_rsp();
        chk("rst_mid_rsp_valid", longint'(rsp_valid), 4);
        #2 reset = 1'b0;
        #1;
        chk("arst_grant", longint'(grant), 0);
        chk("arst_rsp_valid", longint'(rsp_valid), 0);
        chk_mat("arst_rsp_data", rsp_data, '0);
        chk("arst_input_ready", longint'(t_input_ready), 0);
        chk("arst_taken", longint'(t_output_taken), 0);
        chk("arst_t_in_zero", longint'(t_in == '0), 1);
        chk("arst_job_count", longint'(job_count), 0);
        chk("arst_err", longint'(err_proto), 0);
        req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_job(4'b1111, 0, 1'b0);
        chk("post_rst_job_count", longint'(job_count), 1);
        chk("post_rst_err", longint'(err_proto), 0);
        chk("sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
